// File: rtl/nor32_pkg.sv
// Shared constants and types for the 32-bit zero-detect / lowest-set-bit pipeline.
package nor32_pkg;

    localparam int DATA_W = 32;
    localparam int GRP_W  = 4;
    localparam int NGRP   = 8;
    localparam int IDX_W  = 5;
    localparam int GIDX_W = 2;

    typedef logic [GIDX_W-1:0] grp_idx_t;

endpackage

// File: rtl/nor32_1b_sync_if.sv
// Operand in / flag-and-index out bus between the ALU result and flag logic.
interface nor32_1b_sync_if;
    import nor32_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] a;
    logic              out_valid;
    logic              z;
    logic [IDX_W-1:0]  lsb_idx;

    modport master (
        output in_valid,
        output a,
        input  out_valid,
        input  z,
        input  lsb_idx
    );

    modport slave (
        input  in_valid,
        input  a,
        output out_valid,
        output z,
        output lsb_idx
    );

endinterface

// File: rtl/nor32_1b_sync_nor4_grp.sv
// One 4-bit group: any-bit-set flag and the index of its lowest set bit.
module nor4_grp
    import nor32_pkg::*;
(
    input  logic [GRP_W-1:0] g,
    output logic             any,
    output grp_idx_t         idx
);

    // Lowest-first priority within the group; idx is 0 for an empty group.
    always_comb begin
        any = |g;
        idx = '0;
        if (g[0])      idx = 2'd0;
        else if (g[1]) idx = 2'd1;
        else if (g[2]) idx = 2'd2;
        else if (g[3]) idx = 2'd3;
    end

endmodule

// File: rtl/nor32_1b_sync.sv
// Registered 32-bit zero detect with lowest-set-bit index, two-stage pipeline.
// Stage 1 reduces each 4-bit group; stage 2 picks the lowest non-empty group.
module nor32_1b_sync
    import nor32_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    nor32_1b_sync_if.slave  bus
);

    logic [NGRP-1:0]  grp_any_c;
    grp_idx_t         grp_idx_c [NGRP];

    logic             vld_p1;
    logic [NGRP-1:0]  grp_any_p1;
    grp_idx_t         grp_idx_p1 [NGRP];

    logic [IDX_W-1:0] sel_idx_c;

    logic             vld_p2;
    logic             z_p2;
    logic [IDX_W-1:0] lsb_idx_p2;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        nor4_grp u_grp (
            .g   (bus.a[k*GRP_W +: GRP_W]),
            .any (grp_any_c[k]),
            .idx (grp_idx_c[k])
        );
    end

    // ---- stage 1: per-group any/idx, loaded only on a valid beat ----
    // Valid always shifts; group results hold when no operand is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            grp_any_p1 <= '0;
            for (int k = 0; k < NGRP; k++) grp_idx_p1[k] <= '0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                grp_any_p1 <= grp_any_c;
                for (int k = 0; k < NGRP; k++) grp_idx_p1[k] <= grp_idx_c[k];
            end
        end
    end

    // Lowest-first group priority: scanning downward lets the lowest set group win.
    always_comb begin
        sel_idx_c = '0;
        for (int k = NGRP - 1; k >= 0; k--) begin
            if (grp_any_p1[k]) sel_idx_c = {3'(k), grp_idx_p1[k]};
        end
    end

    // ---- stage 2: final flag and index, held while no result is produced ----
    // Reset value z = 1 matches the result for an all-zero operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2     <= 1'b0;
            z_p2       <= 1'b1;
            lsb_idx_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                z_p2       <= ~|grp_any_p1;
                lsb_idx_p2 <= sel_idx_c;
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.z         = z_p2;
    assign bus.lsb_idx   = lsb_idx_p2;

endmodule

// File: tb/tb_nor32_1b_sync.sv
// Bench for nor32_1b_sync: directed scenarios plus a random scoreboard run.
module tb_nor32_1b_sync;

    typedef struct packed {
        logic       z;
        logic [4:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    nor32_1b_sync_if bus ();

    nor32_1b_sync dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: scan bits from the top so the lowest set bit is kept.
    function automatic exp_t model(input logic [31:0] av);
        exp_t r;
        r.z   = (av == 32'h0);
        r.idx = 5'd0;
        for (int i = 31; i >= 0; i--) if (av[i]) r.idx = 5'(i);
        return r;
    endfunction

    task automatic put(input logic v, input logic [31:0] av, input exp_t e);
        bus.in_valid = v;
        bus.a        = av;
        if (v) sb.push_back(e);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.a        = 32'h0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus.out_valid, bus.z, bus.lsb_idx} !== 7'b0_1_00000) begin
            n_bad++;
            $display("FAIL reset_in: got v=%b z=%b idx=%0d want v=0 z=1 idx=0", bus.out_valid, bus.z, bus.lsb_idx);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.out_valid, bus.z, bus.lsb_idx} !== 7'b0_1_00000) begin
            n_bad++;
            $display("FAIL reset_idle: got v=%b z=%b idx=%0d want v=0 z=1 idx=0", bus.out_valid, bus.z, bus.lsb_idx);
        end
    endtask

    task automatic test_single();
        logic [31:0] av [4] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
        exp_t        ex [4] = '{{1'b1, 5'd0}, {1'b0, 5'd0}, {1'b0, 5'd0}, {1'b0, 5'd31}};
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            put(1'b1, av[i], ex[i]);
            @(negedge clk);
            put(1'b0, 32'h0, '0);
            n_vec++;
            if (bus.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL single_early[%0d]: got v=%b want v=0", i, bus.out_valid);
            end
            @(negedge clk);
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            n_vec++;
            if ({bus.out_valid, bus.z, bus.lsb_idx} !== {1'b1, ex[i]}) begin
                n_bad++;
                $display("FAIL single[%0d] a=%h: got v=%b z=%b idx=%0d want v=1 z=%b idx=%0d",
                         i, av[i], bus.out_valid, bus.z, bus.lsb_idx, e.z, e.idx);
            end
            @(negedge clk);
            n_vec++;
            if ({bus.out_valid, bus.z, bus.lsb_idx} !== {1'b0, ex[i]}) begin
                n_bad++;
                $display("FAIL single_hold[%0d]: got v=%b z=%b idx=%0d want v=0 z=%b idx=%0d",
                         i, bus.out_valid, bus.z, bus.lsb_idx, ex[i].z, ex[i].idx);
            end
        end
    endtask

    task automatic test_walking();
        logic [31:0] av [10] = '{32'h0000_0002, 32'h0000_0004, 32'h0000_0008, 32'h0000_0010,
                                 32'h0000_0200, 32'h0000_4000, 32'h0008_0000, 32'h0010_0000,
                                 32'h0200_0000, 32'h4000_0000};
        logic [4:0]  ix [10] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd14, 5'd19, 5'd20, 5'd25, 5'd30};
        exp_t        e;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus.out_valid !== ((c >= 2) && (c < 12))) begin
                n_bad++;
                $display("FAIL walk_valid c=%0d: got v=%b want v=%b", c, bus.out_valid, (c >= 2) && (c < 12));
            end
            if (bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL walk_spurious c=%0d: got out_valid=1 want none", c);
                end else begin
                    e = sb.pop_front();
                    n_vec++;
                    if ({bus.z, bus.lsb_idx} !== e) begin
                        n_bad++;
                        $display("FAIL walk c=%0d: got z=%b idx=%0d want z=%b idx=%0d", c, bus.z, bus.lsb_idx, e.z, e.idx);
                    end
                end
            end
            if (c < 10) put(1'b1, av[c], {1'b0, ix[c]});
            else        put(1'b0, 32'h0, '0);
        end
    endtask

    task automatic test_gapped();
        @(negedge clk);
        put(1'b1, 32'h0000_0200, {1'b0, 5'd9});
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            put(1'b0, 32'hx, '0);
            if (c == 2 && sb.size() > 0) void'(sb.pop_front());
            n_vec++;
            if ({bus.out_valid, bus.z, bus.lsb_idx} !== {(c == 2), 1'b0, 5'd9} && c >= 2) begin
                n_bad++;
                $display("FAIL gapped c=%0d: got v=%b z=%b idx=%0d want v=%b z=0 idx=9",
                         c, bus.out_valid, bus.z, bus.lsb_idx, c == 2);
            end else if (c == 1 && bus.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL gapped_early: got v=%b want v=0", bus.out_valid);
            end
        end
        @(negedge clk);
        bus.a = 32'h0;
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.out_valid, bus.z, bus.lsb_idx} !== 7'b0_1_00000) begin
            n_bad++;
            $display("FAIL async_reset: got v=%b z=%b idx=%0d want v=0 z=1 idx=0", bus.out_valid, bus.z, bus.lsb_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 32'h0000_0000;
        @(negedge clk);
        put(1'b0, 32'h0, '0);
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.out_valid, bus.z, bus.lsb_idx} !== 7'b0_1_00000) begin
                n_bad++;
                $display("FAIL midflight c=%0d: got v=%b z=%b idx=%0d want v=0 z=1 idx=0", c, bus.out_valid, bus.z, bus.lsb_idx);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        put(1'b1, 32'h0000_4000, {1'b0, 5'd14});
        @(negedge clk);
        put(1'b0, 32'h0, '0);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_early: got v=%b want v=0", bus.out_valid);
        end
        @(negedge clk);
        if (sb.size() > 0) void'(sb.pop_front());
        n_vec++;
        if ({bus.out_valid, bus.z, bus.lsb_idx} !== 7'b1_0_01110) begin
            n_bad++;
            $display("FAIL post_reset: got v=%b z=%b idx=%0d want v=1 z=0 idx=14", bus.out_valid, bus.z, bus.lsb_idx);
        end
    endtask

    task automatic test_random();
        int          beats = 0;
        int          idle = 0;
        exp_t        e;
        exp_t        last = {1'b0, 5'd14};
        logic [31:0] av;
        int          r;
        while (beats < 10000 || idle < 4) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL rand_spurious: got out_valid=1 want none");
                end else begin
                    e = sb.pop_front();
                    last = e;
                    n_vec++;
                    if ({bus.z, bus.lsb_idx} !== e) begin
                        n_bad++;
                        $display("FAIL rand: got z=%b idx=%0d want z=%b idx=%0d", bus.z, bus.lsb_idx, e.z, e.idx);
                    end
                end
            end else begin
                n_vec++;
                if ({bus.z, bus.lsb_idx} !== last) begin
                    n_bad++;
                    $display("FAIL rand_hold: got z=%b idx=%0d want z=%b idx=%0d", bus.z, bus.lsb_idx, last.z, last.idx);
                end
            end
            if (beats < 10000 && $urandom_range(0, 4) != 0) begin
                r = $urandom_range(0, 7);
                if (r == 0)      av = 32'h0;
                else if (r <= 2) av = 32'h1 << $urandom_range(0, 31);
                else if (r == 3) av = $urandom & $urandom & $urandom;
                else             av = $urandom;
                put(1'b1, av, model(av));
                beats++;
            end else begin
                put(1'b0, $urandom, '0);
                if (beats >= 10000) idle++;
            end
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL rand_drain: got %0d results outstanding want 0", sb.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_walking();
        test_gapped();
        test_async_reset();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
